// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the multiply-accumulate unit.
// The multiplier and the accumulate stage both take their latency from here.
package mac_pkg;

   localparam int MAC_LATENCY = 11;
   localparam int MAC_PROD_W  = 10;
   localparam int MAC_ACC_W   = 16;
   localparam int MAC_CNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } mac_state_t;

endpackage

// File: rtl/mac_valid_delay.sv
// Shift register carrying {valid, last} alongside the multiplier pipeline so
// the tap lines up with the product that belongs to it.
module mac_valid_delay
   import mac_pkg::*;
#(
   parameter int LATENCY = MAC_LATENCY
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] din,
   output logic [1:0] dout
);

   logic [1:0] stage [LATENCY];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[LATENCY-1];

endmodule

// File: rtl/mac_accumulator.sv
// Accumulate stage behind the pipelined multiplier: sums one frame of products,
// holds the result on a valid/ready output and blocks issue while a frame is in flight.
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int PROD_W   = MAC_PROD_W,
   parameter int ACC_W    = MAC_ACC_W,
   parameter int CNT_W    = MAC_CNT_W,
   parameter int LATENCY  = MAC_LATENCY,
   parameter int SATURATE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic              issue_last,
   output logic              issue_ready,
   input  logic [PROD_W-1:0] prod,
   output logic [ACC_W-1:0]  acc_out,
   output logic [CNT_W-1:0]  term_count,
   output logic              overflow,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        fsm_state
);

   localparam int SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

   mac_state_t        state, state_next;
   logic              accept;
   logic [1:0]        dtap;
   logic              dvalid, dlast;
   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic              ovf;
   logic [SUM_W-1:0]  sum_wide;
   logic              sum_ovf;
   logic [ACC_W-1:0]  acc_sum;
   logic [CNT_W-1:0]  cnt_next;

   // Handshake: an issue counts only when issue_valid and issue_ready are both
   // high at a rising edge; the result moves when out_valid and out_ready are.
   assign issue_ready = (state == IDLE) || (state == ACCUM);
   assign accept      = issue_valid & issue_ready;
   assign out_valid   = (state == HOLD);
   assign fsm_state   = state;

   mac_valid_delay #(.LATENCY(LATENCY)) u_delay (
      .clk   (clk),
      .reset (reset),
      .din   ({accept, accept & issue_last}),
      .dout  (dtap)
   );

   assign dvalid = dtap[1];
   assign dlast  = dtap[0];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = issue_last ? DRAIN : ACCUM;
         ACCUM:   if (accept && issue_last) state_next = DRAIN;
         DRAIN:   if (dvalid && dlast) state_next = HOLD;
         HOLD:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One extra bit above the accumulator exposes the carry out for overflow.
   always_comb begin
      sum_wide = SUM_W'(acc) + SUM_W'(prod);
      sum_ovf  = |sum_wide[SUM_W-1:ACC_W];
      if (sum_ovf && (SATURATE != 0)) acc_sum = '1;
      else                            acc_sum = sum_wide[ACC_W-1:0];
      cnt_next = (cnt == '1) ? cnt : cnt + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if ((state == HOLD) && out_ready) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (dvalid) begin
         acc <= acc_sum;
         cnt <= cnt_next;
         if (sum_ovf) ovf <= 1'b1;
      end
   end

   assign acc_out    = acc;
   assign term_count = cnt;
   assign overflow   = ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a behavioural multiplier pipeline feeds prod,
// expected frame results go into a queue and a monitor checks each presented result.
module tb_mac_accumulator;
   import mac_pkg::*;

   localparam int L     = MAC_LATENCY;
   localparam int EXP_W = 43;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        issue_valid = 1'b0;
   logic        issue_last = 1'b0;
   logic        out_ready = 1'b1;
   logic [3:0]  a_in = '0;
   logic [3:0]  y_in = '0;
   logic [9:0]  prod;
   logic [7:0]  mult_pipe [L];

   logic        issue_ready, overflow, out_valid;
   logic [15:0] acc_out;
   logic [7:0]  term_count;
   logic [1:0]  fsm_state;

   logic        ready_s8, ovf_s8, valid_s8, ready_w8, ovf_w8, valid_w8;
   logic [7:0]  acc_s8, cnt_s8, acc_w8, cnt_w8;
   logic [1:0]  state_s8, state_w8;

   int errors = 0;
   int checks = 0;
   logic [EXP_W-1:0] exp_q[$];
   logic [EXP_W-1:0] mon_e;

   always #5 clk = ~clk;

   initial for (int i = 0; i < L; i++) mult_pipe[i] = '0;

   always @(posedge clk) begin
      mult_pipe[0] <= 8'(a_in) * 8'(y_in);
      for (int i = 1; i < L; i++) mult_pipe[i] <= mult_pipe[i-1];
   end
   assign prod = {2'b00, mult_pipe[L-1]};

   mac_accumulator dut (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_last(issue_last),
      .issue_ready(issue_ready), .prod(prod), .acc_out(acc_out), .term_count(term_count),
      .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready), .fsm_state(fsm_state)
   );

   mac_accumulator #(.ACC_W(8), .SATURATE(1)) dut_s8 (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_last(issue_last),
      .issue_ready(ready_s8), .prod(prod), .acc_out(acc_s8), .term_count(cnt_s8),
      .overflow(ovf_s8), .out_valid(valid_s8), .out_ready(out_ready), .fsm_state(state_s8)
   );

   mac_accumulator #(.ACC_W(8), .SATURATE(0)) dut_w8 (
      .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_last(issue_last),
      .issue_ready(ready_w8), .prod(prod), .acc_out(acc_w8), .term_count(cnt_w8),
      .overflow(ovf_w8), .out_valid(valid_w8), .out_ready(out_ready), .fsm_state(state_w8)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [EXP_W-1:0] pack_exp(input int acc16, input int acc8s, input int acc8w,
                                                 input int cnt, input int ov16, input int ov8s,
                                                 input int ov8w);
      return {16'(acc16), 8'(acc8s), 8'(acc8w), 8'(cnt), 1'(ov16), 1'(ov8s), 1'(ov8w)};
   endfunction

   // Monitor: compare every cycle a result is presented, pop on handshake.
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got acc_out=%0d expected no result", acc_out);
         end else begin
            mon_e = exp_q[0];
            check("acc16",   acc_out,    mon_e[42:27]);
            check("acc8_sat", acc_s8,    mon_e[26:19]);
            check("acc8_wrap", acc_w8,   mon_e[18:11]);
            check("count",   term_count, mon_e[10:3]);
            check("count8",  cnt_w8,     mon_e[10:3]);
            check("ovf16",   overflow,   mon_e[2]);
            check("ovf8_sat", ovf_s8,    mon_e[1]);
            check("ovf8_wrap", ovf_w8,   mon_e[0]);
            check("valid8",  {valid_s8, valid_w8}, 2'b11);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] a, input logic [3:0] y, input logic last);
      issue_valid = 1'b1;
      issue_last  = last;
      a_in        = a;
      y_in        = y;
      step();
      issue_valid = 1'b0;
      issue_last  = 1'b0;
   endtask

   task automatic await_result(input string name);
      int n   = 0;
      int low = 0;
      while (!out_valid && n < 100) begin
         if (!issue_ready) low++;
         step();
         n++;
      end
      check({name, "_latency"}, n, L);
      check({name, "_ready_low"}, low, L);
   endtask

   task automatic accept_result(input string name);
      check({name, "_hold_ready"}, issue_ready, 0);
      step();
      check({name, "_idle_state"}, fsm_state, IDLE);
      check({name, "_idle_ready"}, issue_ready, 1);
      check({name, "_idle_valid"}, out_valid, 0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      reset = 1'b0;
      check("rst_acc",   acc_out, 0);
      check("rst_count", term_count, 0);
      check("rst_ovf",   overflow, 0);
      check("rst_valid", out_valid, 0);
      check("rst_ready", issue_ready, 1);
      check("rst_state", fsm_state, IDLE);
      step();

      // Three back-to-back terms: 15 + 63 + 225.
      exp_q.push_back(pack_exp(303, 255, 47, 3, 0, 1, 1));
      issue(3, 5, 0);
      issue(7, 9, 0);
      issue(15, 15, 1);
      await_result("f3");
      accept_result("f3");

      // Single-term frame.
      exp_q.push_back(pack_exp(225, 225, 225, 1, 0, 0, 0));
      issue(15, 15, 1);
      await_result("f1");
      accept_result("f1");

      // 450 overflows the 8-bit instances: clamp to 255 or wrap to 194.
      exp_q.push_back(pack_exp(450, 255, 194, 2, 0, 1, 1));
      issue(15, 15, 0);
      issue(15, 15, 1);
      await_result("fovf");
      accept_result("fovf");

      // Downstream stall with issue pulses during HOLD.
      out_ready = 1'b0;
      exp_q.push_back(pack_exp(162, 162, 162, 2, 0, 0, 0));
      issue(6, 7, 0);
      issue(10, 12, 1);
      await_result("fstall");
      for (int i = 0; i < 5; i++) begin
         issue_valid = (i % 2 == 0);
         issue_last  = (i % 4 == 0);
         a_in = 15;
         y_in = 15;
         step();
         check("stall_ready", issue_ready, 0);
         check("stall_valid", out_valid, 1);
      end
      issue_valid = 1'b0;
      issue_last  = 1'b0;
      out_ready   = 1'b1;
      accept_result("fstall");
      exp_q.push_back(pack_exp(1, 1, 1, 1, 0, 0, 0));
      issue(1, 1, 1);
      await_result("fpost");
      accept_result("fpost");

      // Reset during DRAIN discards the frame and its in-flight products.
      issue(4, 4, 0);
      issue(4, 4, 1);
      repeat (3) step();
      check("abort_drain", fsm_state, DRAIN);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_state", fsm_state, IDLE);
      check("abort_ready", issue_ready, 1);
      begin
         int seen = 0;
         for (int i = 0; i < L + 4; i++) begin
            if (out_valid) seen++;
            step();
         end
         check("abort_no_valid", seen, 0);
      end
      check("abort_acc", acc_out, 0);
      check("abort_count", term_count, 0);
      exp_q.push_back(pack_exp(4, 4, 4, 1, 0, 0, 0));
      issue(2, 2, 1);
      await_result("fafter");
      accept_result("fafter");

      // Gap between terms: 6 + 25.
      exp_q.push_back(pack_exp(31, 31, 31, 2, 0, 0, 0));
      issue(2, 3, 0);
      repeat (3) step();
      issue(5, 5, 1);
      await_result("fgap");
      accept_result("fgap");

      repeat (3) step();
      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
